// File: rtl/param_fir_engine_if.sv
// -----------------------------------------------------------------------------
// param_fir_engine_if
// Bundles the sample, coefficient-store and status signals of param_fir_engine.
//   master : the driving side (sample source / host), drives the i* signals
//   slave  : the filter engine, drives the o* signals
// Signals:
//   iEnSample, iFirIn          sample strobe and signed sample
//   iCoeffiUpdateFlag          coefficient-update mode request
//   iCsnRam, iWrnRam           coefficient store select / write enable (low)
//   iAddrRam, iWrDtRam         coefficient index and write data
//   iNumOfTap                  active tap count
//   oRdDtRam                   coefficient readback
//   oFirOut, oFirValid         filtered output and its one-cycle valid pulse
//   oBusy, oOverrun            engine busy, sticky dropped-sample flag
// -----------------------------------------------------------------------------
interface param_fir_engine_if #(
  parameter int DW = 3,
  parameter int CW = 16,
  parameter int AW = 6,
  parameter int OW = 16
);
  logic                 iEnSample;
  logic signed [DW-1:0] iFirIn;
  logic                 iCoeffiUpdateFlag;
  logic                 iCsnRam;
  logic                 iWrnRam;
  logic [AW-1:0]        iAddrRam;
  logic signed [CW-1:0] iWrDtRam;
  logic [AW-1:0]        iNumOfTap;
  logic signed [CW-1:0] oRdDtRam;
  logic signed [OW-1:0] oFirOut;
  logic                 oFirValid;
  logic                 oBusy;
  logic                 oOverrun;

  modport master (
    output iEnSample, iFirIn, iCoeffiUpdateFlag, iCsnRam, iWrnRam,
           iAddrRam, iWrDtRam, iNumOfTap,
    input  oRdDtRam, oFirOut, oFirValid, oBusy, oOverrun
  );

  modport slave (
    input  iEnSample, iFirIn, iCoeffiUpdateFlag, iCsnRam, iWrnRam,
           iAddrRam, iWrDtRam, iNumOfTap,
    output oRdDtRam, oFirOut, oFirValid, oBusy, oOverrun
  );
endinterface

// File: rtl/param_fir_engine.sv
// -----------------------------------------------------------------------------
// param_fir_engine
// Time-multiplexed FIR filter: one shared multiply-accumulate walks the active
// taps of a circular delay line once per accepted sample. Coefficients are
// loaded and read back through a small store that is only accessible while
// the engine sits in coefficient-update mode.
// Ports:
//   iClk_12M  system clock
//   iRsn      asynchronous active-low reset
//   bus       param_fir_engine_if.slave (sample, coefficient store, status)
// Optional feature:
//   FIR_ROUND_SAT_EN  when defined, round half-up before the output shift and
//                     saturate to the signed OW range; otherwise truncate and
//                     wrap to the low OW bits.
// -----------------------------------------------------------------------------
module param_fir_engine #(
  parameter int DW    = 3,
  parameter int CW    = 16,
  parameter int NTAP  = 33,
  parameter int AW    = 6,
  parameter int OW    = 16,
  parameter int SHIFT = 0
) (
  input logic               iClk_12M,
  input logic               iRsn,
  param_fir_engine_if.slave bus
);
  localparam int PW   = DW + CW;
  localparam int ACCW = DW + CW + AW;
  localparam logic [AW-1:0] NTAP_A = AW'(NTAP);
  localparam logic [AW-1:0] ONE_A  = AW'(1'b1);
  localparam logic [AW-1:0] ZERO_A = {AW{1'b0}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    MAC    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_r, state_s;

  logic signed [CW-1:0]   coef_r [0:NTAP-1];
  logic signed [DW-1:0]   x_r    [0:NTAP-1];
  logic [AW-1:0]          wptr_r, wptr_nxt_s;
  logic [AW-1:0]          k_r, n_r, n_s, xidx_s;
  logic signed [ACCW-1:0] acc_r;
  logic signed [CW-1:0]   coef_k_s;
  logic signed [DW-1:0]   x_k_s;
  logic signed [PW-1:0]   prod_s;
  logic signed [OW-1:0]   out_s;
  logic                   accept_s, busy_s, overrun_s, mac_last_s;
  logic                   wr_s, rd_s, addr_ok_s;

  logic signed [CW-1:0]   rd_data_r;
  logic signed [OW-1:0]   fir_out_r;
  logic                   valid_r, busy_r, overrun_r;

  // State register.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic; an update request in IDLE wins over a sample strobe.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.iCoeffiUpdateFlag) state_s = UPDATE;
        else if (bus.iEnSample)    state_s = MAC;
        else                       state_s = IDLE;
      end
      UPDATE: begin
        if (!bus.iCoeffiUpdateFlag) state_s = IDLE;
        else                        state_s = UPDATE;
      end
      MAC: begin
        if (mac_last_s) state_s = DONE;
        else            state_s = MAC;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM-derived controls: sample accept, store access, busy and overrun.
  always_comb begin
    accept_s  = (state_r == IDLE) && !bus.iCoeffiUpdateFlag && bus.iEnSample;
    busy_s    = (state_s != IDLE);
    addr_ok_s = (bus.iAddrRam < NTAP_A);
    wr_s      = (state_r == UPDATE) && !bus.iCsnRam && !bus.iWrnRam;
    rd_s      = (state_r == UPDATE) && !bus.iCsnRam && bus.iWrnRam;
    // Entering UPDATE is the only non-reset way to clear the sticky flag.
    if ((state_r == IDLE) && (state_s == UPDATE)) begin
      overrun_s = 1'b0;
    end else if (((state_r == MAC) || (state_r == DONE)) && bus.iEnSample) begin
      overrun_s = 1'b1;
    end else begin
      overrun_s = overrun_r;
    end
  end

  // Tap-count clamp, pointer advance and MAC operand fetch.
  always_comb begin
    if ((bus.iNumOfTap == ZERO_A) || (bus.iNumOfTap > NTAP_A)) n_s = NTAP_A;
    else                                                       n_s = bus.iNumOfTap;
    if (wptr_r == (NTAP_A - ONE_A)) wptr_nxt_s = ZERO_A;
    else                            wptr_nxt_s = wptr_r + ONE_A;
    // Tap k reads the sample written k strobes ago: (wptr - k) mod NTAP.
    if (wptr_r >= k_r) xidx_s = wptr_r - k_r;
    else               xidx_s = wptr_r + (NTAP_A - k_r);
    if (k_r < NTAP_A) coef_k_s = coef_r[k_r];
    else              coef_k_s = {CW{1'b0}};
    if (xidx_s < NTAP_A) x_k_s = x_r[xidx_s];
    else                 x_k_s = {DW{1'b0}};
    prod_s     = $signed({{DW{coef_k_s[CW-1]}}, coef_k_s}) *
                 $signed({{CW{x_k_s[DW-1]}}, x_k_s});
    mac_last_s = (k_r == (n_r - ONE_A));
  end

`ifdef FIR_ROUND_SAT_EN
  localparam logic signed [ACCW:0] RND =
    (SHIFT > 0) ? ((ACCW+1)'(1'b1) << ((SHIFT > 0) ? (SHIFT - 1) : 0))
                : {(ACCW+1){1'b0}};
  localparam logic signed [ACCW:0] OMAX =
    $signed({{(ACCW+2-OW){1'b0}}, {(OW-1){1'b1}}});
  localparam logic signed [ACCW:0] OMIN = ~OMAX;
  logic signed [ACCW:0] scaled_s;

  // Round half-up, arithmetic shift, then clamp to the signed output range.
  always_comb begin
    scaled_s = ($signed({acc_r[ACCW-1], acc_r}) + RND) >>> SHIFT;
    if (scaled_s > OMAX)      out_s = OMAX[OW-1:0];
    else if (scaled_s < OMIN) out_s = OMIN[OW-1:0];
    else                      out_s = scaled_s[OW-1:0];
  end
`else
  // Truncating arithmetic shift; the result wraps to the low OW bits.
  always_comb begin
    out_s = OW'(acc_r >>> SHIFT);
  end
`endif

  // Circular delay line and its write pointer.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      wptr_r <= ZERO_A;
      for (int i = 0; i < NTAP; i++) x_r[i] <= {DW{1'b0}};
    end else if (accept_s) begin
      x_r[wptr_nxt_s] <= bus.iFirIn;
      wptr_r          <= wptr_nxt_s;
    end
  end

  // Coefficient store; out-of-range writes are dropped.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int i = 0; i < NTAP; i++) coef_r[i] <= {CW{1'b0}};
    end else if (wr_s && addr_ok_s) begin
      coef_r[bus.iAddrRam] <= bus.iWrDtRam;
    end
  end

  // Accumulator, tap index and latched tap count.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      acc_r <= {ACCW{1'b0}};
      k_r   <= ZERO_A;
      n_r   <= NTAP_A;
    end else if (accept_s) begin
      acc_r <= {ACCW{1'b0}};
      k_r   <= ZERO_A;
      n_r   <= n_s;
    end else if (state_r == MAC) begin
      acc_r <= acc_r + {{AW{prod_s[PW-1]}}, prod_s};
      k_r   <= k_r + ONE_A;
    end
  end

  // Registered outputs.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      rd_data_r <= {CW{1'b0}};
      fir_out_r <= {OW{1'b0}};
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      valid_r   <= (state_r == DONE);
      busy_r    <= busy_s;
      overrun_r <= overrun_s;
      if (state_r == DONE) fir_out_r <= out_s;
      if (rd_s) rd_data_r <= addr_ok_s ? coef_r[bus.iAddrRam] : {CW{1'b0}};
    end
  end

  assign bus.oRdDtRam  = rd_data_r;
  assign bus.oFirOut   = fir_out_r;
  assign bus.oFirValid = valid_r;
  assign bus.oBusy     = busy_r;
  assign bus.oOverrun  = overrun_r;
endmodule

// File: tb/tb_param_fir_engine.sv
// -----------------------------------------------------------------------------
// tb_param_fir_engine
// Self-checking bench for param_fir_engine: a table of impulse-response
// vectors, randomized samples and coefficients against a sum-of-products
// reference model, and hand-written overrun / update-race / reset sequences.
// -----------------------------------------------------------------------------
module tb_param_fir_engine;
  localparam int DW = 3, CW = 16, NTAP = 33, AW = 6, OW = 16, SHIFT = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  param_fir_engine_if #(.DW(DW), .CW(CW), .AW(AW), .OW(OW)) bus ();

  param_fir_engine #(.DW(DW), .CW(CW), .NTAP(NTAP), .AW(AW), .OW(OW), .SHIFT(SHIFT)) dut (
    .iClk_12M (clk),
    .iRsn     (rst_n),
    .bus      (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: coefficient values and sample history, newest first.
  int coef_m [NTAP];
  int hist_m [NTAP];

  typedef struct {
    int x;
    int nt;
    int exp_out;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string name, input longint got, input longint exp_v);
    checks++;
    if (got != exp_v) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp_v);
    end
  endtask

  function automatic int clamp_n(input int nt);
    return ((nt == 0) || (nt > NTAP)) ? NTAP : nt;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NTAP; i++) begin
      coef_m[i] = 0;
      hist_m[i] = 0;
    end
  endfunction

  function automatic void model_push(input int x);
    for (int i = NTAP - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
    hist_m[0] = x;
  endfunction

  function automatic longint model_out(input int nt);
    longint acc = 0;
    int n = clamp_n(nt);
    for (int k = 0; k < n; k++) acc += longint'(coef_m[k]) * longint'(hist_m[k]);
`ifdef FIR_ROUND_SAT_EN
    if (SHIFT > 0) acc += longint'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0);
    acc = acc >>> SHIFT;
    if (acc > (longint'(1) << (OW - 1)) - 1) acc = (longint'(1) << (OW - 1)) - 1;
    if (acc < -(longint'(1) << (OW - 1)))    acc = -(longint'(1) << (OW - 1));
`else
    acc = acc >>> SHIFT;
    acc = acc & ((longint'(1) << OW) - 1);
    if (acc >= (longint'(1) << (OW - 1))) acc -= (longint'(1) << OW);
`endif
    return acc;
  endfunction

  function automatic int sx3(input int v);
    return (v >= 4) ? v - 8 : v;
  endfunction

  // Strobe one sample and wait (bounded) for its output; optionally inject a
  // second strobe or raise the update flag a given number of cycles in.
  task automatic run_sample(input int x, input int nt, input longint exp_v,
                            input int extra_at, input int flag_at, input string name);
    int  n = clamp_n(nt);
    int  lat = 0;
    bit  seen = 1'b0;
    bus.iFirIn    = DW'(x);
    bus.iNumOfTap = AW'(nt);
    bus.iEnSample = 1'b1;
    @(negedge clk);
    bus.iEnSample = 1'b0;
    check({name, "_busy"}, bus.oBusy, 1);
    check({name, "_vlow"}, bus.oFirValid, 0);
    while (!seen && lat < 80) begin
      @(negedge clk);
      lat++;
      if (lat == extra_at) begin
        bus.iFirIn    = DW'(x + 1);
        bus.iEnSample = 1'b1;
      end else begin
        bus.iEnSample = 1'b0;
      end
      if (lat == flag_at) bus.iCoeffiUpdateFlag = 1'b1;
      if (bus.oFirValid) seen = 1'b1;
    end
    bus.iEnSample = 1'b0;
    if (!seen) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      check({name, "_lat"}, lat, n + 1);
      check({name, "_out"}, bus.oFirOut, exp_v);
    end
  endtask

  task automatic enter_update();
    bus.iCoeffiUpdateFlag = 1'b1;
    @(negedge clk);
  endtask

  task automatic exit_update();
    bus.iCoeffiUpdateFlag = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_coef(input int a, input int d);
    logic signed [CW-1:0] t;
    t = CW'(d);
    bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b0;
    bus.iAddrRam = AW'(a); bus.iWrDtRam = t;
    @(negedge clk);
    bus.iCsnRam = 1'b1; bus.iWrnRam = 1'b1;
    if (a < NTAP) coef_m[a] = int'(t);
  endtask

  task automatic read_coef(input int a, input string name);
    bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b1; bus.iAddrRam = AW'(a);
    @(negedge clk);
    bus.iCsnRam = 1'b1;
    check(name, bus.oRdDtRam, (a < NTAP) ? coef_m[a] : 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_rd"},  bus.oRdDtRam, 0);
    check({name, "_out"}, bus.oFirOut, 0);
    check({name, "_vld"}, bus.oFirValid, 0);
    check({name, "_bsy"}, bus.oBusy, 0);
    check({name, "_ovr"}, bus.oOverrun, 0);
  endtask

  initial begin
    int x, nt;
    bit vseen;
    rst_n = 1'b0;
    bus.iEnSample = 1'b0; bus.iFirIn = '0; bus.iCoeffiUpdateFlag = 1'b0;
    bus.iCsnRam = 1'b1; bus.iWrnRam = 1'b1; bus.iAddrRam = '0;
    bus.iWrDtRam = '0; bus.iNumOfTap = AW'(33);
    model_reset();

    // Impulse / negative impulse / tap-clamp vector table.
    for (int k = 0; k < NTAP; k++) vq.push_back('{(k == 0) ? 1 : 0, 33, k + 1});
    vq.push_back('{0, 33, 0});
    for (int k = 0; k < NTAP; k++) vq.push_back('{(k == 0) ? -4 : 0, 33, -4 * (k + 1)});
    for (int k = 0; k < 5; k++) vq.push_back('{(k == 0) ? 1 : 0, 5, k + 1});
    vq.push_back('{0, 5, 0});
    for (int k = 0; k < NTAP; k++) vq.push_back('{0, 5, 0});
    vq.push_back('{1, 0, 1});
    vq.push_back('{0, 0, 2});
    vq.push_back('{0, 0, 3});
    vq.push_back('{0, 40, 4});

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Coefficients 1..33, readback, out-of-range access.
    enter_update();
    for (int k = 0; k < NTAP; k++) write_coef(k, k + 1);
    write_coef(40, 16'h1234);
    read_coef(0, "rd0");
    read_coef(32, "rd32");
    read_coef(40, "rd40");
    exit_update();
    // A write attempt in IDLE must not reach the store.
    bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b0; bus.iAddrRam = AW'(1); bus.iWrDtRam = 16'sh5555;
    @(negedge clk);
    bus.iCsnRam = 1'b1; bus.iWrnRam = 1'b1;

    foreach (vq[i]) begin
      model_push(vq[i].x);
      run_sample(vq[i].x, vq[i].nt, vq[i].exp_out, 0, 0, $sformatf("vec%0d", i));
    end

    // Random coefficients and samples against the reference model.
    enter_update();
    for (int k = 0; k < NTAP; k++) write_coef(k, int'($urandom_range(0, 65535)));
    for (int i = 0; i < 3; i++) read_coef(int'($urandom_range(0, NTAP - 1)), $sformatf("rdrand%0d", i));
    exit_update();
    for (int i = 0; i < 40; i++) begin
      x  = sx3(int'($urandom_range(0, 7)));
      nt = int'($urandom_range(0, 40));
      model_push(x);
      run_sample(x, nt, model_out(nt), 0, 0, $sformatf("rnd%0d", i));
    end

    // Overrun: second strobe 10 cycles in is dropped.
    check(  "ovr_pre", bus.oOverrun, 0);
    x = sx3(int'($urandom_range(0, 7)));
    model_push(x);
    run_sample(x, 33, model_out(33), 10, 0, "ovr_first");
    check("ovr_set", bus.oOverrun, 1);
    x = sx3(int'($urandom_range(0, 7)));
    model_push(x);
    run_sample(x, 33, model_out(33), 0, 0, "ovr_next");
    check("ovr_sticky", bus.oOverrun, 1);
    enter_update();
    check("ovr_clr", bus.oOverrun, 0);
    exit_update();

    // Update request mid-MAC: output completes, then UPDATE is entered.
    x = sx3(int'($urandom_range(0, 7)));
    model_push(x);
    run_sample(x, 33, model_out(33), 0, 5, "race");
    repeat (2) @(negedge clk);
    check("race_busy", bus.oBusy, 1);
    read_coef(7, "race_rd");
    bus.iFirIn = 3'sd3; bus.iEnSample = 1'b1;
    @(negedge clk);
    bus.iEnSample = 1'b0;
    check("upd_strobe_ovr", bus.oOverrun, 0);
    check("upd_strobe_busy", bus.oBusy, 1);
    exit_update();
    model_push(0);
    run_sample(0, 33, model_out(33), 0, 0, "post_upd");

    // Saturation / wrap: all coefficients 0x7FFF, input 3 held.
    enter_update();
    for (int k = 0; k < NTAP; k++) write_coef(k, 16'h7FFF);
    exit_update();
    for (int i = 0; i < NTAP; i++) begin
      model_push(3);
      run_sample(3, 33, model_out(33), 0, 0, $sformatf("sat%0d", i));
    end
`ifdef FIR_ROUND_SAT_EN
    check("sat_final", bus.oFirOut, 32767);
`else
    check("sat_final", bus.oFirOut, 32669);
`endif

    // Reset in the middle of MAC.
    bus.iFirIn = 3'sd1; bus.iNumOfTap = AW'(33); bus.iEnSample = 1'b1;
    @(negedge clk);
    bus.iEnSample = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    vseen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.oFirValid) vseen = 1'b1;
    end
    check("midrst_novalid", vseen, 0);
    model_push(3);
    run_sample(3, 33, model_out(33), 0, 0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
